mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYC, default 16, giving the maximum number of cycles to wait for mem_ready before faulting.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 The module SHALL have port instruction, input, 32 bits: the current IR contents, valid from DECODE onward.
REQ-005 The module SHALL have port zero, input, 1 bit: the ALU zero flag, sampled in EXEC for branches.
REQ-006 The module SHALL have port mem_ready, input, 1 bit: memory completion for the current access.
REQ-007 The module SHALL have port mem_read, output, 1 bit: memory read request for fetch or load.
REQ-008 The module SHALL have port mem_write, output, 1 bit: memory write request for store.
REQ-009 The module SHALL have port iord, output, 1 bit: memory address select (0 = PC, 1 = ALU result).
REQ-010 The module SHALL have port ir_write, output, 1 bit: IR load strobe.
REQ-011 The module SHALL have port pc_write, output, 1 bit: PC update strobe.
REQ-012 The module SHALL have port pc_src, output, 1 bit: PC source (0 = PC+4, 1 = PC+imm).
REQ-013 The module SHALL have port alu_src_b, output, 1 bit: ALU B-operand select (0 = rs2, 1 = immediate-generator output).
REQ-014 The module SHALL have port alu_op, output, 2 bits: ALU mode (00 = add, 01 = subtract, 10 = funct-decoded).
REQ-015 The module SHALL have port reg_write, output, 1 bit: register-file write strobe.
REQ-016 The module SHALL have port mem_to_reg, output, 1 bit: writeback source (1 = memory data).
REQ-017 The module SHALL have port fault, output, 1 bit: sticky error flag.

Function
REQ-018 The FSM SHALL have states FETCH, DECODE, EXEC, MEM, WB and FAULT.
REQ-019 FETCH SHALL assert mem_read with iord=0, then on mem_ready assert ir_write and pc_write with pc_src=0 in that cycle, and go to DECODE.
REQ-020 DECODE SHALL last one cycle, assert no strobes, and dispatch on opcode instruction[6:0].
REQ-021 Opcodes 0110011, 0010011, 0000011, 0100011 and 1100011 SHALL go to EXEC; any other opcode SHALL go to FAULT.
REQ-022 EXEC, R-type: alu_src_b=0, alu_op=10, next state WB.
REQ-023 EXEC, I-ALU: alu_src_b=1, alu_op=10, next state WB.
REQ-024 EXEC, load or store: alu_src_b=1, alu_op=00, next state MEM.
REQ-025 EXEC, branch: alu_src_b=0 and alu_op=01.
REQ-026 A branch SHALL be taken when funct3=000 and zero=1, or when funct3=001 and zero=0.
REQ-027 A taken branch SHALL assert pc_write with pc_src=1; the branch SHALL then return to FETCH.
REQ-028 A branch with any other funct3 SHALL go to FAULT.
REQ-029 MEM SHALL hold iord=1 and assert mem_read for a load or mem_write for a store until mem_ready.
REQ-030 On mem_ready in MEM, a load SHALL go to WB and a store SHALL go to FETCH.
REQ-031 WB SHALL assert reg_write for exactly one cycle, with mem_to_reg=1 for a load and 0 otherwise, then go to FETCH.
REQ-032 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle mem_ready=0.
REQ-033 When the wait counter reaches TIMEOUT_CYC-1 with mem_ready=0, the FSM SHALL go to FAULT.
REQ-034 mem_ready SHALL be ignored outside FETCH and MEM.
REQ-035 FAULT SHALL set fault=1, hold all strobes at 0, and persist until reset.
REQ-036 All outputs SHALL be decoded from the registered state and opcode (Moore plus opcode), with no combinational path from mem_ready to mem_read or mem_write.
REQ-037 Instruction latency SHALL be, with zero-wait memory: R/I-ALU 4 cycles, load 5, store 4, branch 3.

Reset
REQ-038 reset=1 SHALL immediately force state FETCH, clear the wait counter and clear fault.
REQ-039 Outputs SHALL reset to all strobes 0, iord=0, pc_src=0, alu_src_b=0, alu_op=00, mem_to_reg=0 and fault=0.
REQ-040 A reset asserted mid-access SHALL abandon the access with no completion strobe.
REQ-041 The first mem_read SHALL appear in the first FETCH cycle after reset deasserts.

Structure
REQ-042 Opcode constants, state encodings and alu_op codes SHALL live in a shared package (rv_ctrl_pkg) for reuse by decode, the immediate generator and the ALU control.
REQ-043 The timeout counter SHALL be a sub-module, mem_wait_timer, exposing clear, tick and expired.

Verification
REQ-044 The bench SHALL run add (0x00208033) with zero-wait memory and check reg_write in cycle 4, mem_to_reg=0 and exactly one pc_write.
REQ-045 The bench SHALL run lw (0x0000A083) with mem_ready delayed 3 cycles in MEM and check mem_read held 4 cycles, iord=1, and WB with mem_to_reg=1.
REQ-046 The bench SHALL run beq (0x00000463) with zero=1, expecting pc_write with pc_src=1 in EXEC, then with zero=0, expecting no pc_write in EXEC.
REQ-047 The bench SHALL hold mem_ready=0 in FETCH for TIMEOUT_CYC cycles and check that fault=1 and all strobes stay 0 until reset.
REQ-048 The bench SHALL present opcode 0x7F and check DECODE goes to FAULT, and funct3=010 on a branch goes to FAULT.
REQ-049 The bench SHALL assert reset during MEM of a store and check mem_write drops immediately and FETCH mem_read follows reset release.

Source files
------------

// File: rtl/rv_ctrl_pkg.sv
// Shared control constants for the multi-cycle RV32 datapath: opcodes, FSM
// states, ALU modes and small opcode/branch decode helpers.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_I      = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_BAD    = 3'd5
    } op_cls_t;

    function automatic op_cls_t classify_opcode(input logic [6:0] opcode);
        op_cls_t cls;
        case (opcode)
            OPC_R:      cls = CLS_R;
            OPC_I:      cls = CLS_I;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_BRANCH: cls = CLS_BRANCH;
            default:    cls = CLS_BAD;
        endcase
        return cls;
    endfunction

    function automatic logic branch_supported(input logic [2:0] funct3);
        return (funct3 == F3_BEQ) || (funct3 == F3_BNE);
    endfunction

    function automatic logic branch_taken(input logic [2:0] funct3, input logic zero);
        logic taken;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/mc_control_mem_wait_timer.sv
// Memory wait counter: counts cycles without mem_ready since the last clear and
// flags the final allowed cycle before a timeout.
module mem_wait_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic tick,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] r_count;

    // Wait counter; saturates at LAST so it never wraps back to a safe value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (tick && (r_count != LAST)) begin
            r_count <= r_count + CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign expired = (r_count == LAST);

endmodule

// File: rtl/mc_control.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky FAULT
// state for illegal opcodes, unsupported branches and memory timeouts.
module mc_control
    import rv_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_read,
    output logic        mem_write,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        pc_src,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        fault
);

    state_t     r_state;
    state_t     w_next;
    op_cls_t    r_cls;
    logic [2:0] r_funct3;

    logic       w_expired;
    logic       w_clear;
    logic       w_tick;

    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_iord;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_pc_src;
    logic       w_alu_src_b;
    logic [1:0] w_alu_op;
    logic       w_reg_write;
    logic       w_mem_to_reg;
    logic       w_fault;

    logic       w_unused_ir;
    assign w_unused_ir = ^{instruction[31:15], instruction[11:7]};

    // Counter restarts on every state change so each FETCH/MEM entry gets a full budget.
    assign w_clear = (w_next != r_state);
    assign w_tick  = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !mem_ready;

    mem_wait_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_clear),
        .tick    (w_tick),
        .expired (w_expired)
    );

    // State register plus the instruction class/funct3 captured while in DECODE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_FETCH;
            r_cls    <= CLS_BAD;
            r_funct3 <= 3'b000;
        end else begin
            r_state <= w_next;
            if (r_state == ST_DECODE) begin
                r_cls    <= classify_opcode(instruction[6:0]);
                r_funct3 <= instruction[14:12];
            end else begin
                r_cls    <= r_cls;
                r_funct3 <= r_funct3;
            end
        end
    end

    // Next-state and control decode from the registered state and instruction class.
    always_comb begin
        w_next       = r_state;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_iord       = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = 1'b0;
        w_alu_src_b  = 1'b0;
        w_alu_op     = ALU_ADD;
        w_reg_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_fault      = 1'b0;
        case (r_state)
            ST_FETCH: begin
                w_mem_read = 1'b1;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = ST_DECODE;
                end else if (w_expired) begin
                    w_next = ST_FAULT;
                end else begin
                    w_next = ST_FETCH;
                end
            end
            ST_DECODE: begin
                if (classify_opcode(instruction[6:0]) == CLS_BAD) begin
                    w_next = ST_FAULT;
                end else begin
                    w_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (r_cls)
                    CLS_R: begin
                        w_alu_op = ALU_FUNCT;
                        w_next   = ST_WB;
                    end
                    CLS_I: begin
                        w_alu_src_b = 1'b1;
                        w_alu_op    = ALU_FUNCT;
                        w_next      = ST_WB;
                    end
                    CLS_LOAD, CLS_STORE: begin
                        w_alu_src_b = 1'b1;
                        w_alu_op    = ALU_ADD;
                        w_next      = ST_MEM;
                    end
                    CLS_BRANCH: begin
                        w_alu_op = ALU_SUB;
                        if (!branch_supported(r_funct3)) begin
                            w_next = ST_FAULT;
                        end else if (branch_taken(r_funct3, zero)) begin
                            w_pc_write = 1'b1;
                            w_pc_src   = 1'b1;
                            w_next     = ST_FETCH;
                        end else begin
                            w_next = ST_FETCH;
                        end
                    end
                    default: begin
                        w_next = ST_FAULT;
                    end
                endcase
            end
            ST_MEM: begin
                w_iord      = 1'b1;
                w_mem_read  = (r_cls == CLS_LOAD);
                w_mem_write = (r_cls == CLS_STORE);
                if (mem_ready) begin
                    if (r_cls == CLS_LOAD) begin
                        w_next = ST_WB;
                    end else begin
                        w_next = ST_FETCH;
                    end
                end else if (w_expired) begin
                    w_next = ST_FAULT;
                end else begin
                    w_next = ST_MEM;
                end
            end
            ST_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = (r_cls == CLS_LOAD);
                w_next       = ST_FETCH;
            end
            ST_FAULT: begin
                w_fault = 1'b1;
                w_next  = ST_FAULT;
            end
            default: begin
                w_fault = 1'b1;
                w_next  = ST_FAULT;
            end
        endcase
    end

    // Reset masks every output at once so an in-flight access is dropped without a completion strobe.
    assign mem_read   = w_mem_read   & ~reset;
    assign mem_write  = w_mem_write  & ~reset;
    assign iord       = w_iord       & ~reset;
    assign ir_write   = w_ir_write   & ~reset;
    assign pc_write   = w_pc_write   & ~reset;
    assign pc_src     = w_pc_src     & ~reset;
    assign alu_src_b  = w_alu_src_b  & ~reset;
    assign alu_op     = w_alu_op     & {2{~reset}};
    assign reg_write  = w_reg_write  & ~reset;
    assign mem_to_reg = w_mem_to_reg & ~reset;
    assign fault      = w_fault      & ~reset;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: each stimulus cycle queues the hand-derived
// output vector, and a negedge monitor pops and compares it.
module tb_mc_control;

    localparam int TO = 16;

    localparam logic [11:0] B_FAULT = 12'h800;
    localparam logic [11:0] B_MRD   = 12'h400;
    localparam logic [11:0] B_MWR   = 12'h200;
    localparam logic [11:0] B_IORD  = 12'h100;
    localparam logic [11:0] B_IRW   = 12'h080;
    localparam logic [11:0] B_PCW   = 12'h040;
    localparam logic [11:0] B_PCS   = 12'h020;
    localparam logic [11:0] B_SRCB  = 12'h010;
    localparam logic [11:0] B_FN    = 12'h008;
    localparam logic [11:0] B_SUB   = 12'h004;
    localparam logic [11:0] B_RW    = 12'h002;
    localparam logic [11:0] B_M2R   = 12'h001;
    localparam logic [11:0] B_NONE  = 12'h000;

    localparam logic [31:0] I_ADD   = 32'h00208033;
    localparam logic [31:0] I_ADDI  = 32'h00108093;
    localparam logic [31:0] I_LW    = 32'h0000A083;
    localparam logic [31:0] I_SW    = 32'h0020A023;
    localparam logic [31:0] I_BEQ   = 32'h00000463;
    localparam logic [31:0] I_BNE   = 32'h00001463;
    localparam logic [31:0] I_BF3   = 32'h00002463;
    localparam logic [31:0] I_BAD   = 32'h0000007F;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic        zero;
    logic        mem_ready;
    logic        mem_read;
    logic        mem_write;
    logic        iord;
    logic        ir_write;
    logic        pc_write;
    logic        pc_src;
    logic        alu_src_b;
    logic [1:0]  alu_op;
    logic        reg_write;
    logic        mem_to_reg;
    logic        fault;

    typedef struct {
        string       name;
        logic [11:0] exp;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [11:0] obs;
    assign obs = {fault, mem_read, mem_write, iord, ir_write, pc_write,
                  pc_src, alu_src_b, alu_op, reg_write, mem_to_reg};

    mc_control #(
        .TIMEOUT_CYC(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .iord        (iord),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .pc_src      (pc_src),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .reg_write   (reg_write),
        .mem_to_reg  (mem_to_reg),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_cmp++;
            if (obs !== e.exp) begin
                n_err++;
                $display("FAIL %s: got %03h expected %03h", e.name, obs, e.exp);
            end
        end
    end

    task automatic step(input logic rst, input logic rdy, input logic z,
                        input logic [11:0] e, input string nm);
        exp_t item;
        reset     = rst;
        mem_ready = rdy;
        zero      = z;
        item.name = nm;
        item.exp  = e;
        sb_q.push_back(item);
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] instr, input int waits, input string nm);
        instruction = instr;
        for (int i = 0; i < waits; i++) begin
            step(1'b0, 1'b0, 1'b0, B_MRD, $sformatf("%s_fetch_wait%0d", nm, i));
        end
        step(1'b0, 1'b1, 1'b0, B_MRD | B_IRW | B_PCW, $sformatf("%s_fetch", nm));
    endtask

    task automatic decode(input string nm);
        step(1'b0, 1'b1, 1'b0, B_NONE, $sformatf("%s_decode", nm));
    endtask

    initial begin
        reset       = 1'b1;
        mem_ready   = 1'b0;
        zero        = 1'b0;
        instruction = 32'h0000_0000;
        @(posedge clk);
        #1;

        step(1'b1, 1'b0, 1'b0, B_NONE, "reset_idle");
        step(1'b1, 1'b1, 1'b0, B_NONE, "reset_ready_ignored");

        fetch(I_ADD, 0, "add");
        decode("add");
        step(1'b0, 1'b0, 1'b0, B_FN, "add_exec");
        step(1'b0, 1'b1, 1'b0, B_RW, "add_wb");

        fetch(I_ADDI, 2, "addi");
        decode("addi");
        step(1'b0, 1'b0, 1'b0, B_SRCB | B_FN, "addi_exec");
        step(1'b0, 1'b0, 1'b0, B_RW, "addi_wb");

        fetch(I_LW, 0, "lw");
        decode("lw");
        step(1'b0, 1'b0, 1'b0, B_SRCB, "lw_exec");
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, B_IORD | B_MRD, $sformatf("lw_mem_wait%0d", i));
        end
        step(1'b0, 1'b1, 1'b0, B_IORD | B_MRD, "lw_mem_done");
        step(1'b0, 1'b0, 1'b0, B_RW | B_M2R, "lw_wb");

        // Longest legal wait in both FETCH and MEM: ready arrives on the last allowed cycle.
        fetch(I_SW, TO - 1, "sw_edge");
        decode("sw_edge");
        step(1'b0, 1'b0, 1'b0, B_SRCB, "sw_edge_exec");
        for (int i = 0; i < TO - 1; i++) begin
            step(1'b0, 1'b0, 1'b0, B_IORD | B_MWR, $sformatf("sw_edge_mem_wait%0d", i));
        end
        step(1'b0, 1'b1, 1'b0, B_IORD | B_MWR, "sw_edge_mem_done");

        fetch(I_BEQ, 0, "beq_t");
        decode("beq_t");
        step(1'b0, 1'b0, 1'b1, B_SUB | B_PCW | B_PCS, "beq_taken_exec");

        fetch(I_BEQ, 0, "beq_nt");
        decode("beq_nt");
        step(1'b0, 1'b0, 1'b0, B_SUB, "beq_not_taken_exec");

        fetch(I_BNE, 0, "bne_t");
        decode("bne_t");
        step(1'b0, 1'b0, 1'b0, B_SUB | B_PCW | B_PCS, "bne_taken_exec");

        instruction = I_ADD;
        for (int i = 0; i < TO; i++) begin
            step(1'b0, 1'b0, 1'b0, B_MRD, $sformatf("timeout_fetch_wait%0d", i));
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, i[0], 1'b1, B_FAULT, $sformatf("timeout_fault_sticky%0d", i));
        end
        step(1'b1, 1'b0, 1'b0, B_NONE, "timeout_reset");

        fetch(I_BAD, 0, "badop");
        step(1'b0, 1'b0, 1'b0, B_NONE, "badop_decode");
        step(1'b0, 1'b1, 1'b0, B_FAULT, "badop_fault0");
        step(1'b0, 1'b0, 1'b0, B_FAULT, "badop_fault1");
        step(1'b1, 1'b0, 1'b0, B_NONE, "badop_reset");

        fetch(I_BF3, 0, "bf3");
        decode("bf3");
        step(1'b0, 1'b0, 1'b1, B_SUB, "bf3_exec");
        step(1'b0, 1'b0, 1'b0, B_FAULT, "bf3_fault");
        step(1'b1, 1'b0, 1'b0, B_NONE, "bf3_reset");

        fetch(I_SW, 0, "sw_abort");
        decode("sw_abort");
        step(1'b0, 1'b0, 1'b0, B_SRCB, "sw_abort_exec");
        step(1'b0, 1'b0, 1'b0, B_IORD | B_MWR, "sw_abort_mem");
        step(1'b1, 1'b1, 1'b0, B_NONE, "sw_abort_reset");

        fetch(I_ADD, 1, "post_reset");
        decode("post_reset");
        step(1'b0, 1'b0, 1'b0, B_FN, "post_reset_exec");
        step(1'b0, 1'b0, 1'b0, B_RW, "post_reset_wb");

        @(negedge clk);
        #1;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
